rdm_harq_combine: RTL
=====================

# rdm_harq_combine

Consumes the 128-lane LLR beats delivered by the rate-dematching read FSM and soft-combines them into the per-user HARQ circular buffer. Each accepted beat maps to circular-buffer slot k (wrapping at Ncb). The beat is written directly on the first pass of a first transmission; otherwise it is added lane-wise, with saturation, to the stored HARQ word. The block issues the data request to the FSM and owns the HARQ memory read/write ports.

## Interface
- LLR_W, 6, signed LLR width per lane
- LANES, 128, LLRs per beat
- i_core_clk  in  1  core clock
- i_rx_rstn  in  1  reset; asynchronous assert, active-low
- i_Combine_start  in  1  one-cycle start pulse; sampled only in IDLE
- i_Current_Combine_E01_Size  in  14  beats to consume (E)
- i_Current_Combine_Ncb_Size  in  16  circular-buffer length in beats (Ncb)
- i_First_Transmission  in  1  1 = buffer contents invalid before this job
- i_Harq_Base_Addr  in  16  HARQ word address of slot 0
- o_RDM_Data_Request  out  1  ready to accept a beat
- i_RDM_Data_Valid  in  1  beat present
- i_RDM_Data  in  LANES*LLR_W  beat; lane i at bits [i*LLR_W +: LLR_W]
- o_Harq_Rd_En / o_Harq_Rd_Addr  out  1 / 16  HARQ read; data returns next cycle
- i_Harq_Rd_Data  in  LANES*LLR_W  HARQ read data; read-during-write returns old data
- o_Harq_Wr_En / o_Harq_Wr_Addr / o_Harq_Wr_Data  out  1 / 16 / LANES*LLR_W  HARQ write
- o_Busy  out  1  high outside IDLE
- o_Combine_Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on start if E≠0 and Ncb≠0. Otherwise IDLE→DONE, with no memory access.
- Start is ignored outside IDLE.
- RUN:
  - o_RDM_Data_Request = 1 while accepted count < E.
  - Accept = valid & request. Valid without request is ignored.
  - RUN→DRAIN in the cycle after the E-th accept.
- DRAIN→DONE when the pipeline is empty. DONE→IDLE after one cycle. o_Combine_Done = 1 only in DONE.
- Slot index k starts at 0 and increments per accept. It wraps to 0 when k = Ncb−1. All index and counter registers are cleared on start.
- Pass flag: set on the first wrap and held for the rest of the job.
- combine = !i_First_Transmission | pass_flag, latched per beat at accept.
  - combine = 0: write the beat unmodified; no HARQ read.
  - combine = 1: o_Harq_Rd_En pulses in the accept cycle at address base+k. Lane sum = sat(input + stored).
- Addresses are (base + k) mod 2^16.
- Saturation:
  - Compute a signed (LLR_W+1)-bit sum.
  - Clamp to [−(2^(LLR_W−1)−1), +(2^(LLR_W−1)−1)], i.e. ±31 for LLR_W = 6.
  - −32 inputs take part in the sum before the clamp.
  - Direct writes are not clamped.
- Bypass (needed when Ncb ≤ 2): in combine stage, stored data is taken from the first matching source, in this priority:
  - the write-stage register (write issuing this cycle), if its address matches;
  - else a one-cycle-delayed copy of the previous write, if its address matches;
  - else i_Harq_Rd_Data.
  - Both direct and combined writes feed the bypass.
- Reset mid-job: all state and pipeline registers clear and pending writes are dropped. The next start runs normally.

## Timing
- Reset values: every output is 0.
- Start at cycle T (IDLE): o_Busy = 1 and request = 1 from T+1.
- Beat accepted at cycle A:
  - read (if combine) issues at A;
  - data returns and is combined at A+1;
  - o_Harq_Wr_En = 1 at A+2.
- Throughput: one beat per cycle, with back-to-back accepts allowed.
- Last accept at L: request = 0 from L+1, last write at L+2, DONE pulse at L+3, IDLE at L+4.
- E = 0 or Ncb = 0: DONE pulse at T+1.

## Test plan
- First tx, E=5, Ncb=8, base=0x0100, lane values = beat index:
  - 5 writes to 0x0100..0x0104 with unmodified data;
  - o_Harq_Rd_En never asserted;
  - done pulse 3 cycles after the last accept.
- Retransmission, E=3, Ncb=8, stored +20 in all lanes:
  - input +15 → write +31 (saturated);
  - input −5 → +15;
  - input −32 with stored −20 → −31.
- First tx wrap, E=129, Ncb=110:
  - 110 direct writes;
  - then 19 reads and combined writes to base+0..base+18, each equal to sat(first-pass value + new value).
- Ncb=1, E=4, first tx, back-to-back beats of +3: writes at base carry +3, +6, +9, +12. Repeat with Ncb=2 and check both bypass paths.
- Flow control and start handling:
  - gaps in valid produce no extra accepts;
  - valid with request low is ignored;
  - a start pulse while busy is ignored;
  - E=0 gives a done pulse at T+1 and no memory access.
- Reset mid-run: drop i_rx_rstn after 3 accepts.
  - All outputs go to 0 immediately.
  - After release, a new E=2 job completes with exactly 2 writes.

Source files
------------

// File: rtl/rdm_harq_combine.sv
//------------------------------------------------------------------------------
// rdm_harq_combine
//   Soft-combines 128-lane rate-dematched LLR beats into the HARQ circular buffer.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rdm_harq_combine #(
    parameter int LLR_W = 6,
    parameter int LANES = 128
) (
    input  logic                   i_core_clk,
    input  logic                   i_rx_rstn,
    input  logic                   i_Combine_start,
    input  logic [13:0]            i_Current_Combine_E01_Size,
    input  logic [15:0]            i_Current_Combine_Ncb_Size,
    input  logic                   i_First_Transmission,
    input  logic [15:0]            i_Harq_Base_Addr,
    output logic                   o_RDM_Data_Request,
    input  logic                   i_RDM_Data_Valid,
    input  logic [LANES*LLR_W-1:0] i_RDM_Data,
    output logic                   o_Harq_Rd_En,
    output logic [15:0]            o_Harq_Rd_Addr,
    input  logic [LANES*LLR_W-1:0] i_Harq_Rd_Data,
    output logic                   o_Harq_Wr_En,
    output logic [15:0]            o_Harq_Wr_Addr,
    output logic [LANES*LLR_W-1:0] o_Harq_Wr_Data,
    output logic                   o_Busy,
    output logic                   o_Combine_Done
);

    localparam int DW = LANES * LLR_W;
    localparam logic signed [LLR_W:0] SAT_MAX = (LLR_W+1)'((2 ** (LLR_W - 1)) - 1);
    localparam logic signed [LLR_W:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [13:0]   e_size;
    logic [13:0]   acc_cnt;
    logic [15:0]   ncb;
    logic [15:0]   base;
    logic [15:0]   k;
    logic          first_tx;
    logic          pass_flag;
    logic          req;
    logic          busy;
    logic          done;

    logic          accept;
    logic          combine_now;
    logic [15:0]   slot_addr;

    logic          s1_valid;
    logic          s1_combine;
    logic [15:0]   s1_addr;
    logic [DW-1:0] s1_data;

    logic          wr_en;
    logic [15:0]   wr_addr;
    logic [DW-1:0] wr_data;

    logic          dly_en;
    logic [15:0]   dly_addr;
    logic [DW-1:0] dly_data;

    logic [DW-1:0] stored;
    logic [DW-1:0] combined;
    logic [DW-1:0] wr_next;

    assign accept      = i_RDM_Data_Valid & req;
    assign combine_now = ~first_tx | pass_flag;
    assign slot_addr   = base + k;

    assign o_RDM_Data_Request = req;
    assign o_Harq_Rd_En       = accept & combine_now;
    assign o_Harq_Rd_Addr     = o_Harq_Rd_En ? slot_addr : 16'd0;
    assign o_Harq_Wr_En       = wr_en;
    assign o_Harq_Wr_Addr     = wr_addr;
    assign o_Harq_Wr_Data     = wr_data;
    assign o_Busy             = busy;
    assign o_Combine_Done     = done;

    // Writes from the last two cycles are not yet visible in the memory read data
    assign stored = (wr_en  && (wr_addr  == s1_addr)) ? wr_data  :
                    (dly_en && (dly_addr == s1_addr)) ? dly_data :
                    i_Harq_Rd_Data;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [LLR_W-1:0] llr_in;
            logic signed [LLR_W-1:0] llr_old;
            logic signed [LLR_W:0]   sum;

            assign llr_in  = s1_data[i*LLR_W +: LLR_W];
            assign llr_old = stored[i*LLR_W +: LLR_W];
            assign sum     = {llr_in[LLR_W-1], llr_in} + {llr_old[LLR_W-1], llr_old};
            assign combined[i*LLR_W +: LLR_W] =
                (sum > SAT_MAX) ? SAT_MAX[LLR_W-1:0] :
                (sum < SAT_MIN) ? SAT_MIN[LLR_W-1:0] :
                sum[LLR_W-1:0];
        end
    endgenerate

    assign wr_next = s1_combine ? combined : s1_data;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state     <= IDLE;
            e_size    <= 14'd0;
            acc_cnt   <= 14'd0;
            ncb       <= 16'd0;
            base      <= 16'd0;
            k         <= 16'd0;
            first_tx  <= 1'b0;
            pass_flag <= 1'b0;
            req       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Combine_start) begin
                        e_size    <= i_Current_Combine_E01_Size;
                        ncb       <= i_Current_Combine_Ncb_Size;
                        base      <= i_Harq_Base_Addr;
                        first_tx  <= i_First_Transmission;
                        acc_cnt   <= 14'd0;
                        k         <= 16'd0;
                        pass_flag <= 1'b0;
                        busy      <= 1'b1;
                        if ((i_Current_Combine_E01_Size != 14'd0) &&
                            (i_Current_Combine_Ncb_Size != 16'd0)) begin
                            state <= RUN;
                            req   <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 14'd1;
                        if (k == ncb - 16'd1) begin
                            k         <= 16'd0;
                            pass_flag <= 1'b1;
                        end else begin
                            k <= k + 16'd1;
                        end
                        if (acc_cnt + 14'd1 == e_size) begin
                            req   <= 1'b0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage-1 empty means the final write is issuing this cycle
                    if (!s1_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            s1_valid   <= 1'b0;
            s1_combine <= 1'b0;
            s1_addr    <= 16'd0;
            s1_data    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= 16'd0;
            wr_data    <= '0;
            dly_en     <= 1'b0;
            dly_addr   <= 16'd0;
            dly_data   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_combine <= combine_now;
                s1_addr    <= slot_addr;
                s1_data    <= i_RDM_Data;
            end
            wr_en <= s1_valid;
            if (s1_valid) begin
                wr_addr <= s1_addr;
                wr_data <= wr_next;
            end
            dly_en   <= wr_en;
            dly_addr <= wr_addr;
            dly_data <= wr_data;
        end
    end

endmodule

`default_nettype wire
